// File: rtl/dcache_ctrl.sv
// Write-back, write-allocate, direct-mapped data cache controller with burst refill/writeback.
// Optional CACHE_STATS_EN adds saturating hit/miss/writeback counters.
module dcache_ctrl #(
  parameter int ADDR_W   = 30,
  parameter int DATA_W   = 32,
  parameter int INDEX_W  = 6,
  parameter int OFFSET_W = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cpu_rd,
  input  logic                cpu_wr,
  input  logic [ADDR_W-1:0]   cpu_addr,
  input  logic [DATA_W-1:0]   cpu_wdata,
  input  logic [DATA_W/8-1:0] cpu_be,
  output logic                cpu_stall,
  output logic [DATA_W-1:0]   cpu_rdata,
  output logic                cpu_rvalid,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_ack,
  input  logic [DATA_W-1:0]   mem_rdata
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]         hit_cnt,
  output logic [31:0]         miss_cnt,
  output logic [31:0]         wb_cnt
`endif
);

  localparam int TAG_W  = ADDR_W - INDEX_W - OFFSET_W;
  localparam int LINES  = 1 << INDEX_W;
  localparam int BL     = 1 << OFFSET_W;
  localparam int LA_W   = INDEX_W + OFFSET_W;
  localparam int LINE_W = ADDR_W - OFFSET_W;
  localparam int CNT_W  = (OFFSET_W > 0) ? OFFSET_W : 1;
  localparam int BE_W   = DATA_W / 8;

  typedef enum logic [1:0] {IDLE, WB, REFILL} state_t;
  state_t state, state_nxt;

  logic [TAG_W-1:0]  tag_arr [LINES];
  logic [DATA_W-1:0] data_arr [LINES*BL];
  logic [LINES-1:0]  valid, dirty;
  logic [CNT_W-1:0]  beat;
  logic [LINE_W-1:0] miss_line;

  logic [TAG_W-1:0]   req_tag, miss_tag;
  logic [INDEX_W-1:0] req_idx, miss_idx;
  logic [LA_W-1:0]    req_word, burst_word;
  logic req, hit, idle, acc_hit, acc_miss, last_beat, refill_done;

  assign req_tag    = cpu_addr[ADDR_W-1 -: TAG_W];
  assign req_idx    = cpu_addr[OFFSET_W +: INDEX_W];
  assign req_word   = cpu_addr[LA_W-1:0];
  assign miss_tag   = miss_line[LINE_W-1 -: TAG_W];
  assign miss_idx   = miss_line[INDEX_W-1:0];
  // Word slot of the current burst beat within the flat data array.
  assign burst_word = (LA_W'(miss_idx) << OFFSET_W) | LA_W'(beat);
  assign last_beat  = (beat == CNT_W'(BL - 1));

  assign req         = cpu_rd | cpu_wr;
  assign hit         = req & valid[req_idx] & (tag_arr[req_idx] == req_tag);
  assign idle        = (state == IDLE);
  assign acc_hit     = idle & hit;
  assign acc_miss    = idle & req & ~hit;
  assign cpu_stall   = req & (~idle | ~hit);
  assign refill_done = (state == REFILL) & mem_ack & last_beat;

  // Valid/ready: a CPU request is accepted in the cycle it is presented with cpu_stall=0;
  // a memory beat transfers in each cycle where mem_req=1 and mem_ack=1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state)
      IDLE: begin
        if (acc_miss) state_nxt = (valid[req_idx] & dirty[req_idx]) ? WB : REFILL;
      end
      WB: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = ADDR_W'({tag_arr[miss_idx], miss_idx}) << OFFSET_W;
        mem_wdata = data_arr[burst_word];
        if (mem_ack && last_beat) state_nxt = REFILL;
      end
      REFILL: begin
        mem_req  = 1'b1;
        mem_addr = ADDR_W'(miss_line) << OFFSET_W;
        if (mem_ack && last_beat) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat      <= '0;
      miss_line <= '0;
    end else begin
      if (!idle && mem_ack) beat <= last_beat ? '0 : beat + CNT_W'(1);
      if (acc_miss) miss_line <= cpu_addr[ADDR_W-1:OFFSET_W];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= '0;
      dirty <= '0;
    end else begin
      if (acc_hit && cpu_wr) dirty[req_idx] <= 1'b1;
      if (refill_done) begin
        valid[miss_idx] <= 1'b1;
        dirty[miss_idx] <= 1'b0;
      end
    end
  end

  // Tag and data storage carry no reset; valid gates every use.
  always_ff @(posedge clk) begin
    if (acc_hit && cpu_wr) begin
      for (int b = 0; b < BE_W; b++)
        if (cpu_be[b]) data_arr[req_word][8*b +: 8] <= cpu_wdata[8*b +: 8];
    end
    if ((state == REFILL) && mem_ack) data_arr[burst_word] <= mem_rdata;
    if (refill_done) tag_arr[miss_idx] <= miss_tag;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cpu_rdata  <= '0;
      cpu_rvalid <= 1'b0;
    end else begin
      cpu_rvalid <= acc_hit & cpu_rd & ~cpu_wr;
      if (acc_hit && cpu_rd && !cpu_wr) cpu_rdata <= data_arr[req_word];
    end
  end

`ifdef CACHE_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
      wb_cnt   <= '0;
    end else begin
      if (acc_hit && hit_cnt != '1) hit_cnt <= hit_cnt + 32'd1;
      if (acc_miss && miss_cnt != '1) miss_cnt <= miss_cnt + 32'd1;
      if (acc_miss && valid[req_idx] && dirty[req_idx] && wb_cnt != '1) wb_cnt <= wb_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl: refill, hits, byte merge, dirty writeback, reset mid-burst.
// Counter checks are compiled in when CACHE_STATS_EN is defined.
module tb_dcache_ctrl;
  localparam int ADDR_W = 30;
  localparam int DATA_W = 32;
  localparam int BE_W   = DATA_W / 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              cpu_rd, cpu_wr;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [BE_W-1:0]   cpu_be;
  logic              cpu_stall;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_rvalid;
  logic              mem_req, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;
`ifdef CACHE_STATS_EN
  logic [31:0] hit_cnt, miss_cnt, wb_cnt;
`endif

  int checks = 0;
  int errors = 0;
  logic [DATA_W-1:0] exp_q[$];

  dcache_ctrl dut (
    .clk(clk), .rst(rst),
    .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_be(cpu_be), .cpu_stall(cpu_stall),
    .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
`ifdef CACHE_STATS_EN
    , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .wb_cnt(wb_cnt)
`endif
  );

  // Clock and reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  // Driver tasks
  task automatic drive_idle();
    cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_be = '0;
    mem_ack = 1'b0; mem_rdata = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive_idle();
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (cpu_stall !== 1'b0 || cpu_rvalid !== 1'b0) begin
      errors++; $display("FAIL reset_cpu_flags: stall=%b rvalid=%b want 0 0", cpu_stall, cpu_rvalid);
    end
    checks++;
    if (cpu_rdata !== 32'h0) begin
      errors++; $display("FAIL reset_rdata: got %h want 00000000", cpu_rdata);
    end
    checks++;
    if (mem_req !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 30'h0 || mem_wdata !== 32'h0) begin
      errors++; $display("FAIL reset_mem: req=%b we=%b addr=%h wdata=%h want all 0", mem_req, mem_we, mem_addr, mem_wdata);
    end
`ifdef CACHE_STATS_EN
    checks++;
    if (hit_cnt !== 32'd0 || miss_cnt !== 32'd0 || wb_cnt !== 32'd0) begin
      errors++; $display("FAIL reset_stats: %0d %0d %0d want 0 0 0", hit_cnt, miss_cnt, wb_cnt);
    end
`endif
    rst = 1'b0;
  endtask

  task automatic test_clean_miss();
    int stalls = 0;
    @(negedge clk); cpu_rd = 1'b1; cpu_addr = 30'h10; #1;
    if (cpu_stall) stalls++;
    checks++;
    if (cpu_stall !== 1'b1 || mem_req !== 1'b0) begin
      errors++; $display("FAIL miss_detect: stall=%b req=%b want 1 0", cpu_stall, mem_req);
    end
    for (int b = 0; b < 4; b++) begin
      @(negedge clk); mem_ack = 1'b1; mem_rdata = 32'hA0 + b; #1;
      if (cpu_stall) stalls++;
      checks++;
      if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 30'h10) begin
        errors++; $display("FAIL refill_beat%0d: req=%b we=%b addr=%h want 1 0 10", b, mem_req, mem_we, mem_addr);
      end
    end
    @(negedge clk); mem_ack = 1'b0; #1;
    if (cpu_stall) stalls++;
    checks++;
    if (mem_req !== 1'b0) begin
      errors++; $display("FAIL refill_end_req: got %b want 0", mem_req);
    end
    @(negedge clk); cpu_rd = 1'b0; #1;
    checks++;
    if (stalls != 5) begin
      errors++; $display("FAIL clean_miss_stall: got %0d cycles want 5", stalls);
    end
    checks++;
    if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'hA0) begin
      errors++; $display("FAIL clean_miss_rdata: rvalid=%b rdata=%h want 1 000000a0", cpu_rvalid, cpu_rdata);
    end
  endtask

  task automatic test_read_hit();
    @(negedge clk); cpu_rd = 1'b1; cpu_addr = 30'h11; #1;
    checks++;
    if (cpu_stall !== 1'b0) begin
      errors++; $display("FAIL read_hit_stall: got %b want 0", cpu_stall);
    end
    @(negedge clk); cpu_rd = 1'b0; #1;
    checks++;
    if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'hA1) begin
      errors++; $display("FAIL read_hit_rdata: rvalid=%b rdata=%h want 1 000000a1", cpu_rvalid, cpu_rdata);
    end
  endtask

  task automatic test_write_hit();
    @(negedge clk); cpu_wr = 1'b1; cpu_addr = 30'h12; cpu_wdata = 32'hDEADBEEF; cpu_be = 4'b0011; #1;
    checks++;
    if (cpu_stall !== 1'b0) begin
      errors++; $display("FAIL write_hit_stall: got %b want 0", cpu_stall);
    end
    @(negedge clk); cpu_wr = 1'b0; cpu_be = '0; #1;
    checks++;
    if (cpu_rvalid !== 1'b0) begin
      errors++; $display("FAIL write_hit_rvalid: got %b want 0", cpu_rvalid);
    end
  endtask

  task automatic test_dirty_miss();
    logic [DATA_W-1:0] exp;
    exp_q = {32'hA0, 32'hA1, 32'h0000BEEF, 32'hA3};
    @(negedge clk); cpu_rd = 1'b1; cpu_addr = 30'h1010; #1;
    checks++;
    if (cpu_stall !== 1'b1 || mem_req !== 1'b0) begin
      errors++; $display("FAIL dirty_detect: stall=%b req=%b want 1 0", cpu_stall, mem_req);
    end
    for (int b = 0; b < 4; b++) begin
      @(negedge clk); mem_ack = 1'b1; #1;
      exp = exp_q.pop_front();
      checks++;
      if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 30'h10 || mem_wdata !== exp) begin
        errors++;
        $display("FAIL wb_beat%0d: req=%b we=%b addr=%h wdata=%h want 1 1 10 %h", b, mem_req, mem_we, mem_addr, mem_wdata, exp);
      end
    end
    for (int b = 0; b < 4; b++) begin
      @(negedge clk); mem_ack = 1'b1; mem_rdata = 32'hB0 + b; #1;
      checks++;
      if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 30'h1010) begin
        errors++; $display("FAIL dirty_refill_beat%0d: req=%b we=%b addr=%h want 1 0 1010", b, mem_req, mem_we, mem_addr);
      end
    end
    @(negedge clk); mem_ack = 1'b0; #1;
    checks++;
    if (cpu_stall !== 1'b0 || mem_req !== 1'b0) begin
      errors++; $display("FAIL dirty_complete: stall=%b req=%b want 0 0", cpu_stall, mem_req);
    end
    @(negedge clk); cpu_rd = 1'b0; #1;
    checks++;
    if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'hB0) begin
      errors++; $display("FAIL dirty_rdata: rvalid=%b rdata=%h want 1 000000b0", cpu_rvalid, cpu_rdata);
    end
`ifdef CACHE_STATS_EN
    checks++;
    if (hit_cnt !== 32'd4 || miss_cnt !== 32'd2 || wb_cnt !== 32'd1) begin
      errors++; $display("FAIL stats_seq: hit=%0d miss=%0d wb=%0d want 4 2 1", hit_cnt, miss_cnt, wb_cnt);
    end
`endif
  endtask

  task automatic test_back_to_back();
    @(negedge clk); cpu_rd = 1'b1; cpu_addr = 30'h1013; #1;
    checks++;
    if (cpu_stall !== 1'b0) begin
      errors++; $display("FAIL b2b_first_stall: got %b want 0", cpu_stall);
    end
    @(negedge clk); cpu_addr = 30'h1011; #1;
    checks++;
    if (cpu_stall !== 1'b0 || cpu_rvalid !== 1'b1 || cpu_rdata !== 32'hB3) begin
      errors++; $display("FAIL b2b_second: stall=%b rvalid=%b rdata=%h want 0 1 000000b3", cpu_stall, cpu_rvalid, cpu_rdata);
    end
    // Read and write together is a write; byte enables all off leaves the word intact.
    @(negedge clk); cpu_wr = 1'b1; cpu_addr = 30'h1012; cpu_wdata = 32'hFFFFFFFF; cpu_be = 4'b0000; #1;
    checks++;
    if (cpu_stall !== 1'b0 || cpu_rvalid !== 1'b1 || cpu_rdata !== 32'hB1) begin
      errors++; $display("FAIL b2b_rdwr: stall=%b rvalid=%b rdata=%h want 0 1 000000b1", cpu_stall, cpu_rvalid, cpu_rdata);
    end
    @(negedge clk); cpu_wr = 1'b0; #1;
    checks++;
    if (cpu_stall !== 1'b0 || cpu_rvalid !== 1'b0) begin
      errors++; $display("FAIL b2b_rdwr_rvalid: stall=%b rvalid=%b want 0 0", cpu_stall, cpu_rvalid);
    end
    @(negedge clk); cpu_rd = 1'b0; #1;
    checks++;
    if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'hB2) begin
      errors++; $display("FAIL b2b_be_zero: rvalid=%b rdata=%h want 1 000000b2", cpu_rvalid, cpu_rdata);
    end
    @(negedge clk); #1;
    checks++;
    if (cpu_rvalid !== 1'b0) begin
      errors++; $display("FAIL b2b_rvalid_pulse: got %b want 0", cpu_rvalid);
    end
  endtask

  task automatic test_reset_mid_burst();
    @(negedge clk); mem_ack = 1'b1; mem_rdata = 32'hDEAD0000; #1;
    checks++;
    if (mem_req !== 1'b0 || cpu_stall !== 1'b0) begin
      errors++; $display("FAIL idle_ack: req=%b stall=%b want 0 0", mem_req, cpu_stall);
    end
    @(negedge clk); cpu_rd = 1'b1; cpu_addr = 30'h20; #1;
    @(negedge clk); mem_rdata = 32'hC0; #1;
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 30'h20) begin
      errors++; $display("FAIL partial_req: req=%b addr=%h want 1 20", mem_req, mem_addr);
    end
    @(negedge clk); mem_rdata = 32'hC1;
    @(negedge clk); mem_ack = 1'b0; rst = 1'b1; #1;
    checks++;
    if (mem_req !== 1'b0) begin
      errors++; $display("FAIL rst_req_drop: got %b want 0", mem_req);
    end
    checks++;
    if (cpu_rdata !== 32'h0) begin
      errors++; $display("FAIL rst_rdata: got %h want 00000000", cpu_rdata);
    end
    @(negedge clk); rst = 1'b0; #1;
    checks++;
    if (cpu_stall !== 1'b1 || mem_req !== 1'b0) begin
      errors++; $display("FAIL rst_remiss: stall=%b req=%b want 1 0", cpu_stall, mem_req);
    end
    for (int b = 0; b < 4; b++) begin
      @(negedge clk); mem_ack = 1'b1; mem_rdata = 32'hD0 + b; #1;
      checks++;
      if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 30'h20) begin
        errors++; $display("FAIL rerefill_beat%0d: req=%b we=%b addr=%h want 1 0 20", b, mem_req, mem_we, mem_addr);
      end
    end
    @(negedge clk); mem_ack = 1'b0; #1;
    checks++;
    if (cpu_stall !== 1'b0) begin
      errors++; $display("FAIL rerefill_complete: stall=%b want 0", cpu_stall);
    end
    @(negedge clk); cpu_rd = 1'b0; #1;
    checks++;
    if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'hD0) begin
      errors++; $display("FAIL rerefill_rdata: rvalid=%b rdata=%h want 1 000000d0", cpu_rvalid, cpu_rdata);
    end
`ifdef CACHE_STATS_EN
    checks++;
    if (hit_cnt !== 32'd1 || miss_cnt !== 32'd1 || wb_cnt !== 32'd0) begin
      errors++; $display("FAIL stats_after_rst: hit=%0d miss=%0d wb=%0d want 1 1 0", hit_cnt, miss_cnt, wb_cnt);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_clean_miss();
    test_read_hit();
    test_write_hit();
    test_dirty_miss();
    test_back_to_back();
    test_reset_mid_burst();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dcache_ctrl.md
# dcache_ctrl

Parametrised write-back, write-allocate, direct-mapped data cache controller with multi-word lines and burst refill/writeback. It sits between the CPU memory stage and the external memory port, and replaces the single-word cache control path. It owns its tag, valid, dirty and data arrays, and stalls the pipeline for the full miss sequence.

## Interface

Parameters:

- ADDR_W, 30, CPU word-address width
- DATA_W, 32, word width; must be a multiple of 8
- INDEX_W, 6, set index bits; 2^INDEX_W lines
- OFFSET_W, 2, word-in-line bits; 2^OFFSET_W words per line (burst length BL)
- Derived: TAG_W = ADDR_W-INDEX_W-OFFSET_W; must be at least 1

Ports:

- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- cpu_rd  in  1  read request; held while cpu_stall=1
- cpu_wr  in  1  write request; held while cpu_stall=1
- cpu_addr  in  ADDR_W  word address
- cpu_wdata  in  DATA_W  write data
- cpu_be  in  DATA_W/8  byte enables for writes
- cpu_stall  out  1  combinational; request not yet accepted
- cpu_rdata  out  DATA_W  registered read data
- cpu_rvalid  out  1  one-cycle pulse; cpu_rdata valid
- mem_req  out  1  burst request; held until the last beat
- mem_we  out  1  1 = writeback burst, 0 = refill burst
- mem_addr  out  ADDR_W  line-aligned base address; offset bits = 0
- mem_wdata  out  DATA_W  current writeback beat
- mem_ack  in  1  beat handshake; one beat per cycle with mem_ack=1
- mem_rdata  in  DATA_W  refill beat; sampled when mem_ack=1 and mem_we=0

## Operation

- Address split: tag = cpu_addr[ADDR_W-1:INDEX_W+OFFSET_W], index = next INDEX_W bits, offset = low OFFSET_W bits.
- hit = (cpu_rd|cpu_wr) & valid[index] & (tag_arr[index]==tag), evaluated combinationally from the flop arrays.
- cpu_stall = (cpu_rd|cpu_wr) & ((state!=IDLE) | ~hit).
- cpu_rd and cpu_wr both high: treated as a write; no cpu_rvalid.
- Read hit in IDLE:
  - cpu_rdata <= word at [index][offset] on the next edge.
  - cpu_rvalid pulses for that one cycle.
- Write hit in IDLE: bytes with cpu_be=1 are merged into the word and dirty[index] is set, both at the same edge.
- Miss in IDLE goes to WB if valid & dirty, else to REFILL.
- State WB:
  - mem_req=1, mem_we=1, mem_addr = {victim tag, index, 0}.
  - mem_wdata = victim word[beat].
  - Beat counter increments on each mem_ack.
  - After beat BL-1 is acked: go to REFILL, counter cleared.
- State REFILL:
  - mem_req=1, mem_we=0, mem_addr = {req tag, index, 0}.
  - Each mem_ack writes mem_rdata into word[beat].
  - On the last ack: tag written, valid=1, dirty=0, go to IDLE.
- Back in IDLE the held request hits and completes as a normal hit. A write miss therefore sets dirty only at that completion.
- Beat counter is OFFSET_W bits; it wraps from BL-1 to 0 only through the state exit.
- The miss address is latched on leaving IDLE. A CPU address change during a miss is a protocol violation; the latched address is used.
- OFFSET_W=0 gives single-beat bursts; behaviour is otherwise unchanged.

## Timing

- Reset values:
  - state=IDLE, beat=0, all valid=0, all dirty=0.
  - cpu_rdata=0, cpu_rvalid=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - Tag and data arrays are not reset.
- Hit latency: request accepted in the cycle it is presented (cpu_stall=0); cpu_rvalid follows on the next cycle. Back-to-back hits sustain 1 per cycle.
- Clean miss: cycle 0 detect, cycle 1 mem_req rises. With zero-wait ack, the last beat is in cycle BL. The hit completes in cycle BL+1, so total stall is BL+1 cycles.
- Dirty miss adds BL cycles of WB before REFILL; mem_req stays high across the WB->REFILL boundary.
- mem_ack while mem_req=0 is ignored.
- rst mid-burst: mem_req drops asynchronously, the partial line is discarded, and the line stays invalid.

## Configuration

- CACHE_STATS_EN defined:
  - Adds outputs hit_cnt, miss_cnt and wb_cnt (each 32 bits, reset 0, saturating at 0xFFFFFFFF).
  - hit_cnt increments per completed access in IDLE with hit, including the post-refill completion.
  - miss_cnt increments per IDLE->WB/REFILL transition.
  - wb_cnt increments per WB entry.
- Undefined: the ports and counters are absent; all other behaviour is identical.

## Test plan

- Reset, then read 0x000_0010 with memory returning 0xA0..0xA3 per beat -> mem_req with mem_addr=0x10, mem_we=0, 4 beats; stall 5 cycles; cpu_rdata=0xA0.
- Read 0x11 right after refill -> no stall, cpu_rvalid next cycle, cpu_rdata=0xA1.
- Write 0x12 with cpu_wdata=0xDEADBEEF, cpu_be=4'b0011 -> hit; word becomes 0xA2 upper bytes merged with 0xBEEF; a later read returns 0x0000BEEF (upper bytes 0x0000 from 0xA2).
- Read 0x1010, which maps to the same index as the dirty 0x10 line -> WB burst at mem_addr=0x10 with data 0xA0, 0xA1, 0x0000BEEF, 0xA3, then REFILL at 0x1010; mem_req stays continuously high.
- Assert rst after beat 1 of a refill -> mem_req=0 immediately; re-reading the same address misses again.
- With CACHE_STATS_EN: run the above sequence -> counts hit=4, miss=2, wb=1 (re-run after reset as applicable).
